// File: rtl/pwm_drive_arbiter_pkg.sv
// Shared constants, source encodings and payload types for the motor PWM drive arbiter.
package pwm_drive_arbiter_pkg;

   localparam int unsigned WIDTH_W      = 8;
   localparam int unsigned SRC_W        = 2;
   localparam int unsigned TICKS_PER_MS = 255;
   localparam int unsigned FRAME_TICKS  = 5100;

   localparam logic [WIDTH_W-1:0] NEUTRAL_WIDTH = 8'd127;

   localparam logic [SRC_W-1:0] SRC_NEUTRAL = 2'd0;
   localparam logic [SRC_W-1:0] SRC_HOST    = 2'd1;
   localparam logic [SRC_W-1:0] SRC_RC      = 2'd2;

   // State encoding doubles as the source output code.
   typedef enum logic [SRC_W-1:0] {
      S_NEUTRAL = SRC_NEUTRAL,
      S_HOST    = SRC_HOST,
      S_RC      = SRC_RC
   } drive_state_t;

   typedef struct packed {
      logic [WIDTH_W-1:0] left;
      logic [WIDTH_W-1:0] right;
   } width_pair_t;

endpackage

// File: rtl/pwm_drive_arbiter_slew_limiter.sv
// One PWM channel: registered width that steps toward its target by at most `step` per apply.
module pwm_drive_arbiter_slew_limiter
   import pwm_drive_arbiter_pkg::*;
(
   input  logic               clk_255kHz,
   input  logic               reset,
   input  logic [WIDTH_W-1:0] target,
   input  logic [WIDTH_W-1:0] step,
   input  logic               apply,
   input  logic               force_neutral,
   output logic [WIDTH_W-1:0] width
);

   logic [WIDTH_W:0]   wid9;
   logic [WIDTH_W:0]   tgt9;
   logic [WIDTH_W:0]   step9;
   logic [WIDTH_W-1:0] width_next;

   // 9-bit compare keeps the step from wrapping past 0 or 255.
   always_comb begin
      wid9       = {1'b0, width};
      tgt9       = {1'b0, target};
      step9      = {1'b0, step};
      width_next = target;
      if (tgt9 > wid9) begin
         if ((tgt9 - wid9) > step9) width_next = WIDTH_W'(wid9 + step9);
      end else if ((wid9 - tgt9) > step9) begin
         width_next = WIDTH_W'(wid9 - step9);
      end
   end

   always_ff @(posedge clk_255kHz) begin
      if (reset || force_neutral) width <= NEUTRAL_WIDTH;
      else if (apply)             width <= width_next;
   end

endmodule

// File: rtl/pwm_drive_arbiter.sv
// Chooses neutral / RC / host drive widths once per 20 ms frame, with host watchdog,
// RC confirmation and per-frame slew limiting; pause forces neutral immediately.
module pwm_drive_arbiter
   import pwm_drive_arbiter_pkg::*;
#(
   parameter int unsigned HOST_TIMEOUT_MS   = 250,
   parameter int unsigned SLEW_STEP         = 8,
   parameter int unsigned RC_CONFIRM_FRAMES = 3
) (
   input  logic               clk_255kHz,
   input  logic               reset,
   input  logic               pause,
   input  logic [WIDTH_W-1:0] host_left,
   input  logic [WIDTH_W-1:0] host_right,
   input  logic               host_update,
   input  logic               rc_valid,
   input  logic               rc_override,
   input  logic [WIDTH_W-1:0] rc_left,
   input  logic [WIDTH_W-1:0] rc_right,
   output logic [WIDTH_W-1:0] width_left,
   output logic [WIDTH_W-1:0] width_right,
   output logic [SRC_W-1:0]   source,
   output logic               frame_tick
);

   localparam int unsigned FRAME_W = $clog2(FRAME_TICKS);
   localparam int unsigned WD_W    = 17;
   localparam int unsigned CONF_W  = 4;

   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_TICKS - 1);
   localparam logic [WD_W-1:0]    WD_RELOAD  = WD_W'(HOST_TIMEOUT_MS * TICKS_PER_MS);
   localparam logic [CONF_W-1:0]  CONF_MAX   = CONF_W'(RC_CONFIRM_FRAMES);

   logic [FRAME_W-1:0] frame_cnt;
   logic               boundary;
   logic [WD_W-1:0]    watchdog;
   logic               host_fresh;
   width_pair_t        host_tgt;
   logic [CONF_W-1:0]  conf_cnt;
   logic [CONF_W-1:0]  conf_next;
   logic               rc_ok;
   drive_state_t       state;
   drive_state_t       state_next;
   width_pair_t        tgt;
   logic               apply;

   assign boundary   = (frame_cnt == FRAME_LAST);
   assign host_fresh = (watchdog != '0);

   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_cnt  <= boundary ? '0 : frame_cnt + FRAME_W'(1);
         frame_tick <= boundary;
      end
   end

   // Host watchdog; a reload always beats the decrement.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         watchdog <= '0;
         host_tgt <= '{left: NEUTRAL_WIDTH, right: NEUTRAL_WIDTH};
      end else if (host_update) begin
         watchdog <= WD_RELOAD;
         host_tgt <= '{left: host_left, right: host_right};
      end else if (host_fresh) begin
         watchdog <= watchdog - WD_W'(1);
      end
   end

   always_comb begin
      conf_next = '0;
      if (rc_valid && rc_override)
         conf_next = (conf_cnt == CONF_MAX) ? conf_cnt : conf_cnt + CONF_W'(1);
   end

   assign rc_ok = (conf_next == CONF_MAX);

   always_ff @(posedge clk_255kHz) begin
      if (reset)         conf_cnt <= '0;
      else if (boundary) conf_cnt <= conf_next;
   end

   // Priority selection and the target that goes with the chosen state.
   always_comb begin
      state_next = S_NEUTRAL;
      if (rc_ok)           state_next = S_RC;
      else if (host_fresh) state_next = S_HOST;
      tgt = '{left: NEUTRAL_WIDTH, right: NEUTRAL_WIDTH};
      case (state_next)
         S_RC:    tgt = '{left: rc_left, right: rc_right};
         S_HOST:  tgt = host_tgt;
         default: ;
      endcase
   end

   always_ff @(posedge clk_255kHz) begin
      if (reset || pause) state <= S_NEUTRAL;
      else if (boundary)  state <= state_next;
   end

   assign source = state;
   assign apply  = boundary && !pause;

   pwm_drive_arbiter_slew_limiter u_slew_left (
      .clk_255kHz   (clk_255kHz),
      .reset        (reset),
      .target       (tgt.left),
      .step         (WIDTH_W'(SLEW_STEP)),
      .apply        (apply),
      .force_neutral(pause),
      .width        (width_left)
   );

   pwm_drive_arbiter_slew_limiter u_slew_right (
      .clk_255kHz   (clk_255kHz),
      .reset        (reset),
      .target       (tgt.right),
      .step         (WIDTH_W'(SLEW_STEP)),
      .apply        (apply),
      .force_neutral(pause),
      .width        (width_right)
   );

endmodule

// File: tb/tb_pwm_drive_arbiter.sv
// Directed bench for pwm_drive_arbiter: per-cycle comparison against a frame-level model
// plus hand-computed literal checkpoints.
`timescale 1ns/1ps
module tb_pwm_drive_arbiter;

   localparam int FRAME   = 5100;
   localparam int TMO_MS  = 30;
   localparam int STEP    = 32;
   localparam int CONFIRM = 2;
   localparam int RELOAD  = TMO_MS * 255;

   logic       clk_255kHz = 1'b0;
   logic       reset;
   logic       pause;
   logic [7:0] host_left, host_right;
   logic       host_update;
   logic       rc_valid, rc_override;
   logic [7:0] rc_left, rc_right;
   logic [7:0] width_left, width_right;
   logic [1:0] source;
   logic       frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   pwm_drive_arbiter #(
      .HOST_TIMEOUT_MS  (TMO_MS),
      .SLEW_STEP        (STEP),
      .RC_CONFIRM_FRAMES(CONFIRM)
   ) dut (
      .clk_255kHz (clk_255kHz),
      .reset      (reset),
      .pause      (pause),
      .host_left  (host_left),
      .host_right (host_right),
      .host_update(host_update),
      .rc_valid   (rc_valid),
      .rc_override(rc_override),
      .rc_left    (rc_left),
      .rc_right   (rc_right),
      .width_left (width_left),
      .width_right(width_right),
      .source     (source),
      .frame_tick (frame_tick)
   );

   always #5 clk_255kHz = ~clk_255kHz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Time is cycles since reset release; host freshness is "within RELOAD cycles of
   // the last update"; RC qualification is an unbounded streak of qualifying frames.
   bit m_valid = 0;
   int m_t, e_left, e_right, e_src;
   bit e_tick;
   bit have_upd;
   int last_upd, h_left, h_right, rc_streak;
   bit m_bnd, m_fresh;
   int m_tl, m_tr;

   function automatic int slew(input int w, input int tgt);
      int d;
      d = tgt - w;
      if (d <= STEP && d >= -STEP) return tgt;
      return (d > 0) ? w + STEP : w - STEP;
   endfunction

   always @(posedge clk_255kHz) begin
      if (reset) begin
         m_valid = 1; m_t = 0; e_left = 127; e_right = 127; e_src = 0; e_tick = 0;
         have_upd = 0; last_upd = 0; h_left = 127; h_right = 127; rc_streak = 0;
      end else if (m_valid) begin
         m_bnd  = (m_t % FRAME) == FRAME - 1;
         e_tick = m_bnd;
         if (m_bnd) rc_streak = (rc_valid && rc_override) ? rc_streak + 1 : 0;
         if (pause) begin
            e_src = 0; e_left = 127; e_right = 127;
         end else if (m_bnd) begin
            m_fresh = have_upd && (m_t - last_upd) <= RELOAD;
            if (rc_streak >= CONFIRM) begin
               e_src = 2; m_tl = rc_left; m_tr = rc_right;
            end else if (m_fresh) begin
               e_src = 1; m_tl = h_left; m_tr = h_right;
            end else begin
               e_src = 0; m_tl = 127; m_tr = 127;
            end
            e_left  = slew(e_left, m_tl);
            e_right = slew(e_right, m_tr);
         end
         if (host_update) begin
            have_upd = 1; last_upd = m_t; h_left = host_left; h_right = host_right;
         end
         m_t++;
      end
   end

   always @(negedge clk_255kHz) begin
      if (m_valid) begin
         check("model_width_left",  32'(width_left),  32'(e_left));
         check("model_width_right", 32'(width_right), 32'(e_right));
         check("model_source",      32'(source),      32'(e_src));
         check("model_frame_tick",  32'(frame_tick),  32'(e_tick));
      end
   end

   // ---------------- stimulus ----------------
   task automatic goto(input int target);
      int guard;
      guard = 0;
      while (m_t != target) begin
         @(negedge clk_255kHz);
         guard++;
         if (guard > 70000) begin
            n_checks++; n_fail++;
            $display("FAIL goto_timeout: got t=%0d expected t=%0d", m_t, target);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $fatal(1);
         end
      end
   endtask

   task automatic lit(input string name, input int l, input int r, input int s);
      check({name, "_left"},   32'(width_left),  32'(l));
      check({name, "_right"},  32'(width_right), 32'(r));
      check({name, "_source"}, 32'(source),      32'(s));
   endtask

   task automatic host_pulse(input logic [7:0] l, input logic [7:0] r);
      host_left = l; host_right = r; host_update = 1'b1;
      @(negedge clk_255kHz);
      host_update = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pause = 1'b0; host_left = '0; host_right = '0; host_update = 1'b0;
      rc_valid = 1'b0; rc_override = 1'b0; rc_left = '0; rc_right = '0;
      repeat (3) @(negedge clk_255kHz);
      lit("reset", 127, 127, 0);
      check("reset_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;

      goto(5099); check("tick_before_b1", 32'(frame_tick), 32'd0);
      goto(5100); check("tick_after_b1",  32'(frame_tick), 32'd1);
      goto(5101); check("tick_pulse_end", 32'(frame_tick), 32'd0);
      goto(5105); lit("idle_b1", 127, 127, 0);

      goto(6100);  host_pulse(8'd200, 8'd50);
      goto(10205); lit("host_b2", 159, 95, 1);
      goto(11200); rc_valid = 1'b1; rc_override = 1'b1; host_pulse(8'd200, 8'd50);
      goto(15305); lit("host_b3", 191, 63, 1);
      goto(16300); host_pulse(8'd200, 8'd50);
      goto(20405); lit("rc_take_b4", 159, 31, 2);
      goto(21400); host_pulse(8'd200, 8'd50);
      goto(25505); lit("rc_floor_b5", 127, 0, 2);
      goto(26500); rc_valid = 1'b0; host_pulse(8'd200, 8'd50);
      goto(30605); lit("rc_drop_b6", 159, 32, 1);

      goto(31600); host_pulse(8'd200, 8'd50);
      goto(32600); lit("pre_pause", 159, 32, 1); pause = 1'b1;
      @(negedge clk_255kHz); lit("pause_now", 127, 127, 0);
      goto(35705); lit("pause_hold_b7", 127, 127, 0);
      goto(36700); host_pulse(8'd200, 8'd50);
      goto(37700); pause = 1'b0;
      goto(40805); lit("resume_b8", 159, 95, 1);

      goto(43000); rc_valid = 1'b1; rc_override = 1'b1; rc_left = 8'd250; rc_right = 8'd5;
      goto(45905); lit("expired_b9", 127, 127, 0);
      goto(51005); lit("rc_b10", 159, 95, 2);

      goto(52000); lit("pre_reset", 159, 95, 2);
      reset = 1'b1; rc_valid = 1'b0; rc_override = 1'b0;
      @(negedge clk_255kHz);
      lit("post_reset", 127, 127, 0);
      check("post_reset_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;
      goto(5099); check("re_tick_before", 32'(frame_tick), 32'd0);
      goto(5100); check("re_tick_after",  32'(frame_tick), 32'd1);
      goto(5105); lit("re_idle_b1", 127, 127, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
